// File: rtl/fetch_buffer.sv
// Instruction fetch stage: owns the fetch PC, issues program-memory reads and buffers returning words for the decoder.
// Optional FETCH_STATS_EN adds saturating flush/drop counters with a synchronous clear.
module fetch_buffer #(
   parameter int                ADDR_W     = 8,
   parameter int                DATA_W     = 8,
   parameter int                DEPTH      = 4,
   parameter logic [DATA_W-1:0] NOP_OPCODE = 8'hC8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flush,
   input  logic [ADDR_W-1:0]       flush_addr,
   output logic [ADDR_W-1:0]       pm_address,
   output logic                    pm_rd_en,
   input  logic [DATA_W-1:0]       pm_data,
   output logic [DATA_W-1:0]       ir_data,
   output logic [ADDR_W-1:0]       ir_pc,
   output logic                    ir_valid,
   input  logic                    ir_ready,
   output logic [$clog2(DEPTH):0]  buf_count
`ifdef FETCH_STATS_EN
   ,
   input  logic                    stats_clr,
   output logic [15:0]             flush_count,
   output logic [15:0]             drop_count
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int OW = CW + 1;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] word;
   } entry_t;

   entry_t          fifo [DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count;
   logic [ADDR_W-1:0] pc;
   logic            inflight, issue, push, pop, not_empty;
   logic [OW-1:0]   occupancy;

   // A registered read strobe means its word is on pm_data this cycle.
   assign inflight  = pm_rd_en;
   assign occupancy = {1'b0, count} + OW'(inflight);
   // Counting the in-flight word reserves its slot, so a push never meets a full FIFO without a pop.
   assign issue     = !flush && (occupancy < OW'(DEPTH));
   assign push      = inflight && !flush;
   assign not_empty = (count != '0);
   assign ir_valid  = not_empty && !flush;
   assign pop       = ir_valid && ir_ready;
   assign ir_data   = not_empty ? fifo[rd_ptr].word : NOP_OPCODE;
   assign ir_pc     = not_empty ? fifo[rd_ptr].pc : '0;
   assign buf_count = count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc         <= '0;
         pm_address <= '0;
         pm_rd_en   <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
      end else if (flush) begin
         pc       <= flush_addr;
         pm_rd_en <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else begin
         pm_rd_en <= issue;
         if (issue) begin
            pm_address <= pc;
            pc         <= pc + ADDR_W'(1);
         end
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
      end
   end

   // pm_address still holds the issued address while its data returns.
   always_ff @(posedge clk) begin
      if (push) fifo[wr_ptr] <= '{pc: pm_address, word: pm_data};
   end

`ifdef FETCH_STATS_EN
   logic [16:0] drop_sum;
   assign drop_sum = {1'b0, drop_count} + 17'(occupancy);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flush_count <= '0;
         drop_count  <= '0;
      end else if (stats_clr) begin
         flush_count <= '0;
         drop_count  <= '0;
      end else if (flush) begin
         if (flush_count != 16'hFFFF) flush_count <= flush_count + 16'd1;
         drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
   end
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: reset/throughput vector table, directed flush/wrap/reset sequences, then random traffic
// checked against an in-order instruction-stream model.
module tb_fetch_buffer;
   localparam logic [7:0] NOP = 8'hC8;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       flush = 1'b0;
   logic [7:0] flush_addr = '0;
   logic       ir_ready = 1'b0;
   logic [7:0] pm_address, pm_data, ir_data, ir_pc;
   logic       pm_rd_en, ir_valid;
   logic [2:0] buf_count;
   logic [7:0] mem [256];
`ifdef FETCH_STATS_EN
   logic        stats_clr = 1'b0;
   logic [15:0] flush_count, drop_count;
`endif

   assign pm_data = mem[pm_address];

   fetch_buffer #(.ADDR_W(8), .DATA_W(8), .DEPTH(4), .NOP_OPCODE(8'hC8)) dut (
      .clk(clk), .reset(reset), .flush(flush), .flush_addr(flush_addr),
      .pm_address(pm_address), .pm_rd_en(pm_rd_en), .pm_data(pm_data),
      .ir_data(ir_data), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
      .buf_count(buf_count)
`ifdef FETCH_STATS_EN
      , .stats_clr(stats_clr), .flush_count(flush_count), .drop_count(drop_count)
`endif
   );

   always #5 clk = ~clk;

   int tests = 0;
   int failed = 0;

   typedef struct {
      logic        ready;
      logic [28:0] exp;
   } vec_t;
   vec_t vt [14];

   function automatic logic [28:0] st(input logic v, input logic [7:0] d, input logic [7:0] p,
                                      input logic [2:0] c, input logic r, input logic [7:0] a);
      return {v, d, p, c, r, a};
   endfunction

   function automatic logic [28:0] obs();
      return st(ir_valid, ir_data, ir_pc, buf_count, pm_rd_en, pm_address);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      flush = 1'b0;
      flush_addr = '0;
      ir_ready = 1'b0;
`ifdef FETCH_STATS_EN
      stats_clr = 1'b0;
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] epc;
      logic [7:0] exp_pc;
      logic       fl, rdy;
      logic [7:0] fa;
      int         since;

      for (int i = 0; i < 256; i++) mem[i] = 8'(i + 16);

      // Reset state while reset is held
      #12;
      chk("reset_state", obs(), st(1'b0, NOP, 8'h00, 3'd0, 1'b0, 8'h00));

      // First word at cycle 2, then one per cycle
      do_reset();
      ir_ready = 1'b1;
      step(); chk("A_e1", obs(), st(1'b0, NOP, 8'h00, 3'd0, 1'b1, 8'h00));
      step(); chk("A_e2", {ir_valid, ir_data, ir_pc}, {1'b1, 8'h10, 8'h00});
      step(); chk("A_e3", {ir_valid, ir_data, ir_pc}, {1'b1, 8'h11, 8'h01});
      step(); chk("A_e4", {ir_valid, ir_data, ir_pc}, {1'b1, 8'h12, 8'h02});

      // Backpressure table: fill to 4, stall, then release
      vt[0]  = '{ready: 1'b0, exp: st(1'b0, NOP,   8'h00, 3'd0, 1'b1, 8'h00)};
      vt[1]  = '{ready: 1'b0, exp: st(1'b1, 8'h10, 8'h00, 3'd1, 1'b1, 8'h01)};
      vt[2]  = '{ready: 1'b0, exp: st(1'b1, 8'h10, 8'h00, 3'd2, 1'b1, 8'h02)};
      vt[3]  = '{ready: 1'b0, exp: st(1'b1, 8'h10, 8'h00, 3'd3, 1'b1, 8'h03)};
      for (int k = 4; k < 10; k++)
         vt[k] = '{ready: 1'b0, exp: st(1'b1, 8'h10, 8'h00, 3'd4, 1'b0, 8'h03)};
      vt[10] = '{ready: 1'b1, exp: st(1'b1, 8'h11, 8'h01, 3'd3, 1'b0, 8'h03)};
      vt[11] = '{ready: 1'b1, exp: st(1'b1, 8'h12, 8'h02, 3'd2, 1'b1, 8'h04)};
      vt[12] = '{ready: 1'b1, exp: st(1'b1, 8'h13, 8'h03, 3'd2, 1'b1, 8'h05)};
      vt[13] = '{ready: 1'b1, exp: st(1'b1, 8'h14, 8'h04, 3'd2, 1'b1, 8'h06)};
      do_reset();
      for (int k = 0; k < 14; k++) begin
         ir_ready = vt[k].ready;
         step();
         chk($sformatf("B_e%0d", k + 1), obs(), vt[k].exp);
      end

      // Flush over 3 buffered entries plus a word in flight
      do_reset();
      repeat (4) step();
      chk("C_pre_count", {buf_count, pm_rd_en}, {3'd3, 1'b1});
      flush = 1'b1; flush_addr = 8'h40;
      #1;
      chk("C_flush_cycle_valid", ir_valid, 1'b0);
      step(); flush = 1'b0;
      #1;
      chk("C_n1", {ir_valid, ir_data, ir_pc, buf_count, pm_rd_en}, {1'b0, NOP, 8'h00, 3'd0, 1'b0});
      step();
      chk("C_n2", {ir_valid, pm_rd_en, pm_address}, {1'b0, 1'b1, 8'h40});
      step();
      chk("C_n3", {ir_valid, ir_data, ir_pc, buf_count}, {1'b1, 8'h50, 8'h40, 3'd1});
`ifdef FETCH_STATS_EN
      chk("C_stats", {flush_count, drop_count}, {16'd1, 16'd4});
      stats_clr = 1'b1;
      step();
      stats_clr = 1'b0;
      chk("C_stats_clr", {flush_count, drop_count}, 32'd0);
`endif

      // Back-to-back flushes: the last target wins
      do_reset();
      ir_ready = 1'b1;
      repeat (3) step();
      flush = 1'b1; flush_addr = 8'h20;
      step();
      flush_addr = 8'h30;
      step();
      flush = 1'b0;
      #1;
      chk("D_n1", ir_valid, 1'b0);
      step(); chk("D_n2", ir_valid, 1'b0);
      step(); chk("D_n3", {ir_valid, ir_pc, ir_data}, {1'b1, 8'h30, 8'h40});
      step(); chk("D_n4", {ir_valid, ir_pc, ir_data}, {1'b1, 8'h31, 8'h41});

      // PC wrap through 8'hFF
      flush = 1'b1; flush_addr = 8'hFE;
      step();
      flush = 1'b0;
      step(); step();
      epc = 8'hFE;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("E_wrap%0d", i), {ir_valid, ir_pc}, {1'b1, epc});
         epc = epc + 8'd1;
         step();
      end

      // Asynchronous reset mid-cycle with data buffered and a read in flight
      do_reset();
      repeat (4) step();
      #2 reset = 1'b0;
      #1;
      chk("F_async_reset", obs(), st(1'b0, NOP, 8'h00, 3'd0, 1'b0, 8'h00));
`ifdef FETCH_STATS_EN
      chk("F_stats_reset", {flush_count, drop_count}, 32'd0);
`endif

      // Random traffic against an in-order stream model
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      do_reset();
      exp_pc = 8'h00;
      since = 0;
      for (int n = 0; n < 3000; n++) begin
         fl  = ($urandom_range(0, 99) < 6);
         rdy = ($urandom_range(0, 99) < 70);
         fa  = 8'($urandom);
         flush = fl; flush_addr = fa; ir_ready = rdy;
         #1;
         if (fl) begin
            chk("rnd_flush_valid", ir_valid, 1'b0);
         end else begin
            if (since == 2) chk("rnd_latency", ir_valid, 1'b1);
            if (ir_valid) begin
               chk("rnd_pc", ir_pc, exp_pc);
               chk("rnd_data", ir_data, mem[exp_pc]);
            end else begin
               chk("rnd_empty", {ir_data, ir_pc, buf_count}, {NOP, 8'h00, 3'd0});
            end
         end
         chk("rnd_bound", buf_count <= 3'd4, 1'b1);
         if (fl) begin
            exp_pc = fa;
            since = 0;
         end else begin
            if (ir_valid && rdy) exp_pc = exp_pc + 8'd1;
            if (since < 3) since++;
         end
         @(posedge clk);
         #1;
      end
      flush = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Instruction fetch stage between the program memory and the instruction decoder.
- Owns the fetch PC, issues program-memory reads and captures returning words into a small prefetch FIFO.
- Presents the oldest word to the decoder through a valid/ready handshake.
- On a taken jump (flush), discards all buffered and in-flight words, redirects the PC and presents the NOP opcode until new words arrive.

Parameters:
- ADDR_W, 8, program-memory address width.
- DATA_W, 8, instruction word width.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- NOP_OPCODE, 8'hC8, word presented while the FIFO is empty.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  taken jump; redirect fetch this cycle.
- flush_addr  input  ADDR_W  jump target; sampled when flush=1.
- pm_address  output  ADDR_W  program-memory read address (registered).
- pm_rd_en  output  1  read strobe (registered); data returns exactly 1 cycle later.
- pm_data  input  DATA_W  program-memory read data.
- ir_data  output  DATA_W  FIFO head word, or NOP_OPCODE when empty.
- ir_pc  output  ADDR_W  address of ir_data; 0 when empty.
- ir_valid  output  1  head word valid.
- ir_ready  input  1  decoder accepts the head word.
- buf_count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async assert, sync release):
  - pc=0, pm_address=0, pm_rd_en=0, FIFO empty, buf_count=0, ir_valid=0.
  - ir_data=NOP_OPCODE, ir_pc=0, in-flight flag=0.
- Issue rule: each cycle with flush=0 and (buf_count + inflight) < DEPTH:
  - pm_address<=pc, pm_rd_en<=1, pc<=pc+1.
  - Otherwise pm_rd_en<=0 and pc holds.
  - Guarantees no overflow regardless of ir_ready.
- Capture: a cycle after pm_rd_en=1, pm_data and its address are pushed, unless a flush occurred in between.
- Pop: ir_valid && ir_ready removes the head entry.
  - Simultaneous push and pop leaves buf_count unchanged.
  - Pop and push are legal when full only if pop and push coincide; the issue rule prevents any other full-push.
- Output: ir_data, ir_pc and ir_valid are combinational from the FIFO head.
  - Empty → ir_data=NOP_OPCODE, ir_valid=0.
- Flush (flush=1 at edge N):
  - FIFO cleared and the in-flight read tagged stale; its data at edge N+1 is dropped.
  - pc<=flush_addr and pm_rd_en<=0 at edge N.
  - First read of flush_addr issued at edge N+1; first valid word from flush_addr at cycle N+2.
  - ir_valid is forced 0 during the flush cycle, so a pop cannot occur.
  - Back-to-back flushes: the last one wins; each discards everything older.
- Wrap: pc increments modulo 2^ADDR_W, so 8'hFF→8'h00 with no special handling.
- Reset mid-operation clears everything immediately, including stale tags.
- Steady-state throughput: 1 word/cycle with ir_ready held 1. The first word after reset is valid at cycle 2.

Optional Feature:
- FETCH_STATS_EN defined adds output flush_count (16 bits), output drop_count (16 bits) and input stats_clr.
  - flush_count increments on each flush cycle.
  - drop_count increments per discarded word: buffered entries cleared plus a stale in-flight word.
  - Both counters saturate at 16'hFFFF and clear on reset or stats_clr=1.
- Without the macro these ports and counters are absent; core behaviour is identical.

Test Plan:
- Reset release, memory holds addr→addr+8'h10, ir_ready=1 → ir_valid rises at cycle 2 with ir_data 8'h10, ir_pc 0, then 8'h11, 8'h12 on consecutive cycles.
- ir_ready=0 for 10 cycles after reset → buf_count saturates at 4, pm_rd_en low when 4 entries + inflight reach 4. Releasing ir_ready yields 8'h10..8'h13 with no gap, loss or duplication.
- flush=1, flush_addr=8'h40 while 3 entries are buffered → next cycle ir_valid=0 and ir_data=8'hC8; two cycles after the flush ir_data=8'h50, ir_pc=8'h40; no stale word appears.
- Flush on consecutive cycles to 8'h20 then 8'h30 → only words from 8'h30 onward reach the decoder.
- flush_addr=8'hFE with continuous ready → ir_pc sequence FE, FF, 00, 01.
- Reset asserted with a full FIFO and a read in flight → all outputs return to reset values asynchronously. With FETCH_STATS_EN, a flush over 3 entries plus inflight gives drop_count=4 and flush_count=1.
